// File: rtl/branch_flag_resolver.sv
// branch_flag_resolver: execute-stage branch resolution, mispredict/redirect generation; optional stats via MOR1KX_BRANCH_RESOLVER_STATS_EN
module branch_flag_resolver #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int DELAY_SLOT = 1,
  parameter int STAT_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            decode_op_bf_i,
  input  logic                            decode_op_bnf_i,
  input  logic                            decode_predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
  input  logic                            padv_execute_i,
  input  logic                            execute_flag_i,
  input  logic                            execute_flag_valid_i,
  input  logic                            pipeline_flush_i,
  output logic                            prev_op_brcond_o,
  output logic                            execute_op_bf_o,
  output logic                            execute_op_bnf_o,
  output logic                            resolved_flag_o,
  output logic                            branch_mispredict_o,
  output logic                            redirect_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            resolve_stall_o,
  output logic [STAT_CNT_WIDTH-1:0]       stat_branches_o,
  output logic [STAT_CNT_WIDTH-1:0]       stat_mispredicts_o
);
  localparam logic [OPTION_OPERAND_WIDTH-1:0] STEP = DELAY_SLOT != 0 ? OPTION_OPERAND_WIDTH'(8) : OPTION_OPERAND_WIDTH'(4);
  typedef enum logic [1:0] {IDLE, WAIT_FLAG, RESOLVED} state_t;
  state_t state, state_nxt;
  logic pred;
  logic [OPTION_OPERAND_WIDTH-1:0] pc, target;
  logic capture, enter, taken, mispredict;
  always_comb begin
    capture = padv_decode_i & (decode_op_bf_i | decode_op_bnf_i) & !pipeline_flush_i &
              (state == IDLE | (state == RESOLVED & padv_execute_i));
    enter = state == WAIT_FLAG & execute_flag_valid_i & !pipeline_flush_i;
    taken = (execute_op_bf_o & execute_flag_i) | (execute_op_bnf_o & !execute_flag_i);
    mispredict = taken ^ pred;
    state_nxt = pipeline_flush_i ? IDLE :
                enter ? RESOLVED :
                capture ? WAIT_FLAG :
                (state == RESOLVED & padv_execute_i) ? IDLE : state;
  end
  assign prev_op_brcond_o = state != IDLE;
  assign resolve_stall_o = state == WAIT_FLAG;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      execute_op_bf_o <= 1'b0;
      execute_op_bnf_o <= 1'b0;
      pred <= 1'b0;
      pc <= '0;
      target <= '0;
      resolved_flag_o <= 1'b0;
      branch_mispredict_o <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        execute_op_bf_o <= decode_op_bf_i;
        execute_op_bnf_o <= decode_op_bnf_i & !decode_op_bf_i;
        pred <= decode_predicted_flag_i;
        pc <= decode_pc_i;
        target <= decode_target_i;
      end else if (state_nxt == IDLE) begin
        execute_op_bf_o <= 1'b0;
        execute_op_bnf_o <= 1'b0;
      end
      if (enter) begin
        resolved_flag_o <= execute_flag_i;
        branch_mispredict_o <= mispredict;
        redirect_valid_o <= mispredict;
        redirect_pc_o <= taken ? target : pc + STEP;
      end else begin
        redirect_valid_o <= 1'b0;
        if (state_nxt != RESOLVED) branch_mispredict_o <= 1'b0;
      end
    end
  end
`ifdef MOR1KX_BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_o <= '0;
      stat_mispredicts_o <= '0;
    end else if (enter) begin
      stat_branches_o <= stat_branches_o + STAT_CNT_WIDTH'(stat_branches_o != '1);
      stat_mispredicts_o <= stat_mispredicts_o + STAT_CNT_WIDTH'(mispredict & (stat_mispredicts_o != '1));
    end
  end
`else
  assign stat_branches_o = '0;
  assign stat_mispredicts_o = '0;
`endif
endmodule

// File: doc/branch_flag_resolver.md
Name: branch_flag_resolver

Overview:
Execute-stage partner of the gshare direction predictor. It captures each conditional branch (l.bf/l.bnf) and its predicted direction when decode advances, then waits until the architectural flag is valid in execute. It resolves the actual direction, flags a misprediction and supplies the redirect PC to fetch. It also drives the predictor's history and FSM update inputs: prev_op_brcond, execute_op_bf/bnf, flag and branch_mispredict.

Parameters:
OPTION_OPERAND_WIDTH, 32, PC/target width
DELAY_SLOT, 1, 1: fall-through = pc+8; 0: fall-through = pc+4
STAT_CNT_WIDTH, 16, width of optional statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
padv_decode_i  in  1  decode stage advances
decode_op_bf_i  in  1  insn in decode is l.bf
decode_op_bnf_i  in  1  insn in decode is l.bnf
decode_predicted_flag_i  in  1  predictor output; 1 = predicted taken
decode_pc_i  in  W  PC of branch in decode
decode_target_i  in  W  computed branch target
padv_execute_i  in  1  execute stage advances (branch retires from execute)
execute_flag_i  in  1  architectural SR[F] in execute
execute_flag_valid_i  in  1  execute_flag_i is final
pipeline_flush_i  in  1  exception/flush kills the in-flight branch
prev_op_brcond_o  out  1  conditional branch occupies execute
execute_op_bf_o  out  1  captured op was l.bf
execute_op_bnf_o  out  1  captured op was l.bnf
resolved_flag_o  out  1  latched flag used for resolution
branch_mispredict_o  out  1  resolved direction != predicted
redirect_valid_o  out  1  one-cycle fetch redirect request
redirect_pc_o  out  W  correct next PC
resolve_stall_o  out  1  execute must not advance (waiting for flag)
stat_branches_o  out  STAT_CNT_WIDTH  resolved branch count (optional)
stat_mispredicts_o  out  STAT_CNT_WIDTH  mispredict count (optional)

Behaviour:
- States: IDLE, WAIT_FLAG, RESOLVED. Reset: IDLE; all outputs 0; captured registers 0.
- Capture happens when padv_decode_i & (decode_op_bf_i | decode_op_bnf_i) & !pipeline_flush_i, and the state is IDLE or the state is RESOLVED with padv_execute_i. On capture, latch op_bf, op_bnf, predicted flag, pc and target, then go to WAIT_FLAG next cycle.
- Capture in WAIT_FLAG, or in RESOLVED without padv_execute_i, is a protocol violation. It is ignored and the state is held.
- WAIT_FLAG:
  - resolve_stall_o = 1.
  - If execute_flag_valid_i: latch resolved_flag = execute_flag_i and go to RESOLVED.
  - padv_execute_i in WAIT_FLAG is ignored.
- Resolution, registered on entry to RESOLVED:
  - taken = (bf & flag) | (bnf & !flag).
  - mispredict = taken XOR predicted.
  - redirect_pc = taken ? target : pc + (DELAY_SLOT ? 8 : 4), modulo 2^W.
- RESOLVED:
  - branch_mispredict_o is held at level for the whole state.
  - redirect_valid_o = mispredict, only in the first RESOLVED cycle (single pulse).
  - redirect_pc_o is held stable for the whole state.
  - On padv_execute_i: go to WAIT_FLAG on a simultaneous new capture, otherwise IDLE.
- prev_op_brcond_o, execute_op_bf_o and execute_op_bnf_o are 1/valid in WAIT_FLAG and RESOLVED, 0 in IDLE.
- Flag latency: the earliest flag is sampled in the cycle after capture, so the earliest mispredict/redirect is 2 cycles after the capture edge.
- pipeline_flush_i has the highest priority in every state. Next state is IDLE, any simultaneous capture is dropped, and no redirect is issued. A pending redirect pulse in the same cycle is still output, because it is registered.
- bf and bnf both asserted in decode: bf wins, bnf is captured as 0.
- Outputs are registered except resolve_stall_o and prev_op_brcond_o, which decode directly from the state register.

Optional Feature:
MOR1KX_BRANCH_RESOLVER_STATS_EN:
- Defined:
  - stat_branches_o increments on every entry to RESOLVED.
  - stat_mispredicts_o increments on entries where mispredict = 1.
  - Both saturate at all-ones and reset to 0.
  - Flushed branches are not counted.
- Undefined: both outputs are tied to 0 and no counter logic is instantiated.

Test Plan:
- Correct prediction: capture l.bf, predicted=1, pc=0x100, target=0x200. Next cycle flag_valid=1, flag=1. Required: RESOLVED, mispredict=0, redirect_valid never 1, redirect_pc=0x200.
- Mispredicted fall-through: capture l.bnf, predicted=1, pc=0x100, DELAY_SLOT=1. Flag=1 valid. Required: mispredict=1 level, redirect_valid single pulse, redirect_pc=0x108.
- Flag wait: capture, then flag_valid=0 for 3 cycles. Required: resolve_stall_o=1 and prev_op_brcond_o=1 for 3 cycles; padv_execute_i during them ignored. Resolves on the 4th cycle.
- Back-to-back branches: in RESOLVED, padv_execute_i and a new l.bf capture in the same cycle. Required: direct transition to WAIT_FLAG with the new pc latched, no IDLE cycle.
- Flush: in WAIT_FLAG, assert pipeline_flush_i with flag_valid=1 and a simultaneous capture. Required: IDLE next cycle, no redirect, no capture, stats unchanged.
- Wrap and saturation: pc=0xFFFF_FFFC, not-taken mispredict, DELAY_SLOT=1. Required: redirect_pc=0x0000_0004. With STATS_EN and STAT_CNT_WIDTH=2, after 5 mispredicts both counters read 3.
